// File: rtl/rom_rd_pipe.sv
// rom_rd_pipe: pipelined ROM read stage with in-order error responses and a credit-limited response FIFO
module rom_rd_pipe #(
    parameter int abits        = 17,
    parameter int dbits        = 64,
    parameter int latency      = 2,
    parameter int fifo_depth   = 4,
    parameter int sysbus_abits = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    input  logic [sysbus_abits-1:0] i_req_addr,
    input  logic                    i_req_write,
    output logic                    o_req_ready,
    output logic                    o_resp_valid,
    output logic [dbits-1:0]        o_resp_rdata,
    output logic                    o_resp_err,
    input  logic                    i_resp_ready,
    output logic                    o_mem_en,
    output logic [abits-1:0]        o_mem_addr,
    input  logic [dbits-1:0]        i_mem_rdata
);
    localparam int pw = $clog2(fifo_depth);
    localparam int cw = pw + 1;

    logic [latency-1:0] tag_v;
    logic [latency-1:0] tag_e;
    logic [dbits-1:0]   fifo_d [fifo_depth];
    logic [fifo_depth-1:0] fifo_e;
    logic [pw-1:0]      wr_ptr;
    logic [pw-1:0]      rd_ptr;
    logic [cw-1:0]      fifo_cnt;
    logic [cw-1:0]      outstanding;
    logic               accept;
    logic               req_err;
    logic               push;
    logic               pop;

    // credits cover both in-flight tags and queued responses, so a tag never finds the FIFO full
    assign o_req_ready  = !i_rst && (outstanding < cw'(fifo_depth));
    assign accept       = i_req_valid & o_req_ready;
    assign req_err      = i_req_write | (|i_req_addr[sysbus_abits-1:abits]);
    assign o_mem_en     = accept & !req_err;
    assign o_mem_addr   = i_req_addr[abits-1:0];
    assign push         = tag_v[latency-1];
    assign o_resp_valid = !i_rst && (fifo_cnt != '0);
    assign pop          = o_resp_valid & i_resp_ready;
    assign o_resp_rdata = o_resp_valid ? fifo_d[rd_ptr] : '0;
    assign o_resp_err   = o_resp_valid & fifo_e[rd_ptr];

    // tag shift register: mirrors the macro latency, errors ride along to keep ordering
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tag_v <= '0;
            tag_e <= '0;
        end else begin
            tag_v[0] <= accept;
            tag_e[0] <= req_err;
            for (int i = 1; i < latency; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_e[i] <= tag_e[i-1];
            end
        end
    end

    // response storage; error entries carry zero data
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_d[wr_ptr] <= tag_e[latency-1] ? '0 : i_mem_rdata;
            fifo_e[wr_ptr] <= tag_e[latency-1];
        end
    end

    // pointers wrap naturally; occupancy and credits tracked by counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
        end else begin
            wr_ptr      <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr      <= pop ? rd_ptr + 1'b1 : rd_ptr;
            fifo_cnt    <= fifo_cnt + cw'(push) - cw'(pop);
            outstanding <= outstanding + cw'(accept) - cw'(pop);
        end
    end
endmodule

// File: tb/tb_rom_rd_pipe.sv
// tb_rom_rd_pipe: randomized and directed checks of rom_rd_pipe against a timestamped response queue
module tb_rom_rd_pipe;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int AB    = 17;

    logic        clk = 0;
    logic        rst = 1;
    logic        req_valid = 0;
    logic [31:0] req_addr = 0;
    logic        req_write = 0;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        resp_ready = 1;
    logic        mem_en;
    logic [AB-1:0] mem_addr;
    logic [63:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    rom_rd_pipe #(.abits(AB), .dbits(64), .latency(LAT), .fifo_depth(DEPTH), .sysbus_abits(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_addr(req_addr),
        .i_req_write(req_write), .o_req_ready(req_ready), .o_resp_valid(resp_valid),
        .o_resp_rdata(resp_rdata), .o_resp_err(resp_err), .i_resp_ready(resp_ready),
        .o_mem_en(mem_en), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rom(input logic [31:0] a);
        return (a == 32'h10) ? 64'h1122334455667788 : {32'hC0DE0000 | a, ~a};
    endfunction

    // macro model: data appears LAT cycles after the enable, garbage otherwise
    logic [63:0] mpipe [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
        mpipe[0] <= mem_en ? rom({15'b0, mem_addr}) : {$urandom, $urandom};
    end
    assign mem_rdata = mpipe[LAT-1];

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, got, exp, cyc);
        end
    endtask

    // reference: every accepted request becomes a response visible LAT+1 cycles later, in order
    typedef struct { logic [63:0] d; logic e; int t; } resp_t;
    resp_t q[$];

    always @(negedge clk) begin
        bit acc, err, hv, pp;
        cyc++;
        if (rst) begin
            q.delete();
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_rdata", resp_rdata, 0);
            chk("rst_err", resp_err, 0);
        end else begin
            err = req_write || (req_addr[31:AB] != 0);
            acc = req_valid && (q.size() < DEPTH);
            hv  = (q.size() > 0) && (q[0].t <= cyc);
            chk("req_ready", req_ready, q.size() < DEPTH);
            chk("mem_en", mem_en, acc && !err);
            if (acc && !err) chk("mem_addr", mem_addr, req_addr[AB-1:0]);
            chk("resp_valid", resp_valid, hv);
            if (hv) begin
                chk("resp_rdata", resp_rdata, q[0].d);
                chk("resp_err", resp_err, q[0].e);
            end
            pp = hv && resp_ready;
            if (pp) void'(q.pop_front());
            if (acc) q.push_back('{err ? 64'h0 : rom({15'b0, req_addr[AB-1:0]}), err, cyc + LAT + 1});
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [31:0] ea [4];
        logic        ew [4];
        logic        ee [4];
        ea = '{32'h08, 32'h08, 32'h1 << 17, 32'h10};
        ew = '{0, 1, 0, 0};
        ee = '{0, 1, 1, 0};

        step(); step();
        @(negedge clk);
        chk("lit_reset_ready", req_ready, 0);
        chk("lit_reset_valid", resp_valid, 0);
        step();
        rst = 0;

        // single read
        req_valid = 1; req_addr = 32'h10; req_write = 0;
        @(negedge clk);
        chk("lit_single_en", mem_en, 1);
        chk("lit_single_addr", mem_addr, 17'h10);
        step(); req_valid = 0;
        step();
        @(negedge clk);
        chk("lit_single_early", resp_valid, 0);
        step();
        @(negedge clk);
        chk("lit_single_valid", resp_valid, 1);
        chk("lit_single_data", resp_rdata, 64'h1122334455667788);
        chk("lit_single_err", resp_err, 0);
        idle(2);

        // back-to-back
        for (int k = 0; k < 4; k++) begin
            req_valid = 1; req_addr = 32'(k * 8);
            @(negedge clk);
            chk("lit_b2b_ready", req_ready, 1);
            step();
        end
        idle(6);

        // back-pressure
        resp_ready = 0; n = 0;
        for (int k = 0; k < 6; k++) begin
            req_valid = 1; req_addr = 32'(k * 8);
            @(negedge clk);
            if (req_ready) n++;
            step();
        end
        req_valid = 0;
        @(negedge clk);
        chk("lit_bp_ready_low", req_ready, 0);
        chk("lit_bp_accepts", n, 4);
        idle(3);
        resp_ready = 1;
        @(negedge clk);
        chk("lit_bp_ready_pop", req_ready, 0);
        chk("lit_bp_head", resp_rdata, 64'hC0DE0000FFFFFFFF);
        step();
        @(negedge clk);
        chk("lit_bp_ready_back", req_ready, 1);
        idle(6);

        // interleaved errors
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                req_valid = 1; req_addr = ea[k]; req_write = ew[k];
            end else begin
                req_valid = 0; req_write = 0;
            end
            @(negedge clk);
            if (mem_en) n++;
            if (k >= 3 && k <= 6) begin
                chk("lit_err_valid", resp_valid, 1);
                chk("lit_err_flag", resp_err, ee[k-3]);
            end
            if (k == 3) chk("lit_err_data0", resp_rdata, 64'hC0DE0008FFFFFFF7);
            if (k == 4 || k == 5) chk("lit_err_zero", resp_rdata, 0);
            if (k == 6) chk("lit_err_data3", resp_rdata, 64'h1122334455667788);
            step();
        end
        chk("lit_err_pulses", n, 2);
        idle(4);

        // random traffic
        for (int k = 0; k < 300; k++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_write  = ($urandom_range(0, 9) == 0);
            req_addr   = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h20000) : $urandom_range(0, 32'h1FFFF);
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        // saturated requests with random consumer
        req_write = 0;
        for (int k = 0; k < 100; k++) begin
            req_valid  = 1;
            req_addr   = $urandom_range(0, 32'h1FFFF);
            resp_ready = $urandom_range(0, 1);
            step();
        end
        resp_ready = 1;
        idle(8);

        // reset mid-burst
        for (int k = 0; k < 3; k++) begin
            req_valid = 1; req_addr = 32'h30 + 32'(k * 8);
            step();
        end
        req_valid = 0; rst = 1;
        @(negedge clk);
        chk("lit_midrst_valid", resp_valid, 0);
        step(); step();
        rst = 0;
        req_valid = 1; req_addr = 32'h20;
        @(negedge clk);
        chk("lit_post_ready", req_ready, 1);
        step(); req_valid = 0;
        @(negedge clk);
        chk("lit_post_stale1", resp_valid, 0);
        step();
        @(negedge clk);
        chk("lit_post_stale2", resp_valid, 0);
        step();
        @(negedge clk);
        chk("lit_post_valid", resp_valid, 1);
        chk("lit_post_data", resp_rdata, 64'hC0DE0020FFFFFFDF);
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
